// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package clk_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  localparam int MIN_DIV  = 2;
  localparam int CH_IDX_W = 4;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, active divisor, shadow divisor and registered outputs.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 20,
  parameter int DEFAULT_DIV = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  ch_state_e        state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [CNT_W-1:0] div, nxt_div;
  logic [CNT_W-1:0] shadow, nxt_shadow;
  logic             pending, nxt_pending;
  logic             nxt_clk, nxt_tick;
  logic             last;

  assign last = (cnt == div - CNT_W'(1));

  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt;
    nxt_div     = div;
    nxt_shadow  = shadow;
    nxt_pending = pending;
    case (state)
      IDLE: begin
        nxt_cnt = '0;
        // An idle channel has no period to protect, so a load takes effect at once.
        if (load) begin
          nxt_div     = load_div;
          nxt_shadow  = load_div;
          nxt_pending = 1'b0;
        end else if (pending) begin
          nxt_div     = shadow;
          nxt_pending = 1'b0;
        end
        if (en) nxt_state = RUN;
      end
      RUN: begin
        if (sync || last) begin
          nxt_cnt = '0;
          if (pending) begin
            nxt_div     = shadow;
            nxt_pending = 1'b0;
          end
          if (!sync && !en) nxt_state = IDLE;
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
        // A load landing on a boundary is held for the following boundary.
        if (load) begin
          nxt_shadow  = load_div;
          nxt_pending = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
    nxt_clk  = (nxt_state == RUN) && (nxt_cnt < (nxt_div >> 1));
    nxt_tick = (nxt_state == RUN) && (nxt_cnt == nxt_div - CNT_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      div     <= DEF_DIV;
      shadow  <= DEF_DIV;
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      div     <= nxt_div;
      shadow  <= nxt_shadow;
      pending <= nxt_pending;
      clk_out <= nxt_clk;
      tick    <= nxt_tick;
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// N_CH independent programmable clock dividers with shared sync and a single load port.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 20,
  parameter int DEFAULT_DIV = 500000
) (
  input  logic                clk_50mhz,
  input  logic                rst,
  input  logic [N_CH-1:0]     en,
  input  logic                sync,
  input  logic                load_en,
  input  logic [CH_IDX_W-1:0] load_ch,
  input  logic [CNT_W-1:0]    load_div,
  output logic                load_err,
  output logic [N_CH-1:0]     clk_out,
  output logic [N_CH-1:0]     tick
);

  // load_en is a single-cycle strobe with no back-pressure: a write is either taken
  // that cycle or rejected with a load_err pulse in the next cycle.
  logic load_ok;
  assign load_ok = ({1'b0, load_ch} < (CH_IDX_W + 1)'(N_CH)) &&
                   (load_div >= CNT_W'(MIN_DIV));

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (clk_50mhz),
      .rst      (rst),
      .en       (en[c]),
      .sync     (sync),
      .load     (load_en && load_ok && (load_ch == CH_IDX_W'(c))),
      .load_div (load_div),
      .clk_out  (clk_out[c]),
      .tick     (tick[c])
    );
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) load_err <= 1'b0;
    else     load_err <= load_en && !load_ok;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed plan steps followed by random traffic.
module tb_clk_div_multi;

  localparam int N_CH = 2;
  localparam int CNT_W = 8;
  localparam int DEF = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_CH-1:0]  en;
  logic             sync;
  logic             load_en;
  logic [3:0]       load_ch;
  logic [CNT_W-1:0] load_div;
  logic             load_err;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;

  clk_div_multi #(
    .N_CH        (N_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk_50mhz (clk),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .load_en   (load_en),
    .load_ch   (load_ch),
    .load_div  (load_div),
    .load_err  (load_err),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: each running channel remembers the cycle its period started.
  int cyc;
  int m_run[N_CH];
  int m_start[N_CH];
  int m_div[N_CH];
  int m_shadow[N_CH];
  int m_pend[N_CH];
  logic [0:0] exp_q[$];

  function automatic int pos(int c);
    return cyc - m_start[c];
  endfunction

  function automatic logic exp_clk(int c);
    return (m_run[c] != 0) && (pos(c) < m_div[c] / 2);
  endfunction

  function automatic logic exp_tick(int c);
    return (m_run[c] != 0) && (pos(c) == m_div[c] - 1);
  endfunction

  task automatic model_reset();
    cyc = 0;
    exp_q.delete();
    for (int c = 0; c < N_CH; c++) begin
      m_run[c] = 0; m_start[c] = 0; m_div[c] = DEF; m_shadow[c] = DEF; m_pend[c] = 0;
    end
  endtask

  task automatic model_edge();
    bit valid;
    bit ld;
    valid = (int'(load_ch) < N_CH) && (int'(load_div) >= 2);
    exp_q.push_back(load_en && !valid);
    for (int c = 0; c < N_CH; c++) begin
      ld = load_en && valid && (int'(load_ch) == c);
      if (m_run[c] == 0) begin
        if (ld) begin
          m_div[c] = load_div; m_shadow[c] = load_div; m_pend[c] = 0;
        end else if (m_pend[c] != 0) begin
          m_div[c] = m_shadow[c]; m_pend[c] = 0;
        end
        if (en[c]) begin
          m_run[c] = 1; m_start[c] = cyc + 1;
        end
      end else begin
        if (sync || pos(c) == m_div[c] - 1) begin
          if (m_pend[c] != 0) begin
            m_div[c] = m_shadow[c]; m_pend[c] = 0;
          end
          if (sync || en[c]) m_start[c] = cyc + 1;
          else m_run[c] = 0;
        end
        if (ld) begin
          m_shadow[c] = load_div; m_pend[c] = 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [0:0] e_err;
    e_err = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      check($sformatf("clk_out[%0d]@%0d", c, cyc), 32'(clk_out[c]), 32'(exp_clk(c)));
      check($sformatf("tick[%0d]@%0d", c, cyc), 32'(tick[c]), 32'(exp_tick(c)));
    end
    check($sformatf("load_err@%0d", cyc), 32'(load_err), 32'(e_err));
  endtask

  task automatic step(input logic [N_CH-1:0] e, input logic s, input logic le,
                      input logic [3:0] lc, input logic [CNT_W-1:0] ld);
    en = e; sync = s; load_en = le; load_ch = lc; load_div = ld;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_steps(input logic [N_CH-1:0] e, input int n);
    for (int i = 0; i < n; i++) step(e, 1'b0, 1'b0, 4'd0, 8'd0);
  endtask

  logic [3:0] pat;
  logic [N_CH-1:0] r_en;

  initial begin
    rst = 1'b1; en = '0; sync = 1'b0; load_en = 1'b0; load_ch = '0; load_div = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    compare_all();
    rst = 1'b0;

    // 1: ch0 at the default divisor, ch1 idle
    pat = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      step(2'b01, 1'b0, 1'b0, 4'd0, 8'd0);
      check("p1_pattern", 32'(clk_out[0]), 32'(pat[i % 4]));
      check("p1_ch1_idle", 32'(clk_out[1]), 32'd0);
    end

    // 2: mid-period reloads of ch0
    step(2'b01, 1'b0, 1'b1, 4'd0, 8'd6);
    idle_steps(2'b01, 16);
    step(2'b01, 1'b0, 1'b1, 4'd0, 8'd5);
    idle_steps(2'b01, 14);

    // 3: rejected loads
    step(2'b01, 1'b0, 1'b1, 4'd0, 8'd1);
    check("p3_err_div", 32'(load_err), 32'd1);
    step(2'b01, 1'b0, 1'b1, 4'd3, 8'd6);
    check("p3_err_ch", 32'(load_err), 32'd1);
    idle_steps(2'b01, 10);

    // 4: drop en at cnt=1; the period completes before going idle
    for (int k = 0; k < 20 && pos(0) != 1; k++) step(2'b01, 1'b0, 1'b0, 4'd0, 8'd0);
    idle_steps(2'b00, 10);
    check("p4_idle_clk", 32'(clk_out[0]), 32'd0);

    // 5: both channels running, sync, then sync on ch0's last cycle
    step(2'b00, 1'b0, 1'b1, 4'd0, 8'd4);
    step(2'b00, 1'b0, 1'b1, 4'd1, 8'd6);
    idle_steps(2'b11, 7);
    step(2'b11, 1'b1, 1'b0, 4'd0, 8'd0);
    check("p5_sync_clk", 32'(clk_out), 32'b11);
    idle_steps(2'b11, 5);
    for (int k = 0; k < 20 && pos(0) != 3; k++) step(2'b11, 1'b0, 1'b0, 4'd0, 8'd0);
    check("p5_wrap_tick", 32'(tick[0]), 32'd1);
    step(2'b10, 1'b1, 1'b0, 4'd0, 8'd0);
    check("p5_wrap_sync_clk", 32'(clk_out), 32'b11);
    idle_steps(2'b11, 9);

    // 6: asynchronous reset in ch0's high phase with load_err asserted
    for (int k = 0; k < 20 && pos(0) != m_div[0] - 1; k++) step(2'b11, 1'b0, 1'b0, 4'd0, 8'd0);
    step(2'b11, 1'b0, 1'b1, 4'd9, 8'd7);
    check("p6_pre_clk", 32'(clk_out[0]), 32'd1);
    check("p6_pre_err", 32'(load_err), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("p6_async_clk", 32'(clk_out), 32'd0);
    check("p6_async_tick", 32'(tick), 32'd0);
    check("p6_async_err", 32'(load_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    compare_all();
    for (int i = 0; i < 8; i++) begin
      step(2'b11, 1'b0, 1'b0, 4'd0, 8'd0);
      check("p6_div4_ch0", 32'(clk_out[0]), 32'(pat[i % 4]));
      check("p6_div4_ch1", 32'(clk_out[1]), 32'(pat[i % 4]));
    end

    // Random traffic against the model
    r_en = 2'b11;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) r_en = N_CH'($urandom_range(0, 3));
      step(r_en, ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 7) == 0),
           4'($urandom_range(0, 3)),
           8'($urandom_range(0, 9)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
